// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline. It sits beside
// decode and combines load-use, branch-operand, multi-cycle EX and data-memory
// wait conditions into one prioritised set of pipeline register controls.
// Two saturating performance counters record stall cycles and branch redirects.

module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES    = 1,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           if_id_rs1,
  input  logic [4:0]           if_id_rs2,
  input  logic                 if_id_uses_rs1,
  input  logic                 if_id_uses_rs2,
  input  logic                 if_id_is_branch,
  input  logic                 id_ex_MemRead,
  input  logic                 id_ex_RegWrite,
  input  logic [4:0]           id_ex_rd,
  input  logic                 branch_taken,
  input  logic                 ex_busy,
  input  logic                 mem_stall,
  output logic                 PCWrite,
  output logic                 FetchWrite,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 id_ex_write,
  output logic                 ex_mem_write,
  output logic                 ex_mem_bubble,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  // Down-counter load values. A load-use hazard spends its first bubble cycle
  // in RUN, so LOAD_STALL covers the remaining LOAD_USE_CYCLES-1 cycles. A
  // taken branch spends its first flush cycle in RUN and FLUSH exits after the
  // cycle where cnt is already zero, so it is loaded with FLUSH_CYCLES-2.
  localparam logic [1:0] LOAD_CNT_INIT =
    2'((LOAD_USE_CYCLES > 1) ? (LOAD_USE_CYCLES - 1) : 0);
  localparam logic [1:0] FLUSH_CNT_INIT =
    2'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t     state;
  state_t     state_next;
  state_t     saved_state;
  state_t     saved_state_next;
  state_t     eff_state;
  logic [1:0] cnt;
  logic [1:0] cnt_next;

  logic       src_match;
  logic       rd_nonzero;
  logic       load_use;
  logic       br_dep;
  logic       take_branch;

  logic       core_pc_write;
  logic       core_fetch_write;
  logic       core_if_id_flush;
  logic       core_id_ex_bubble;
  logic       core_id_ex_write;
  logic       core_ex_mem_write;
  logic       core_ex_mem_bubble;

  // Hazard detection: compare decode sources with the EX destination; x0 never matches.
  always_comb begin
    src_match  = (if_id_uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                 (if_id_uses_rs2 && (if_id_rs2 == id_ex_rd));
    rd_nonzero = (id_ex_rd != 5'd0);
    load_use   = id_ex_MemRead && rd_nonzero && src_match;
    br_dep     = if_id_is_branch && id_ex_RegWrite && !id_ex_MemRead &&
                 rd_nonzero && src_match;
  end

  // While frozen the state register holds MEM_WAIT; decisions use the state saved on entry.
  always_comb begin
    eff_state = (state == MEM_WAIT) ? saved_state : state;
  end

  // Prioritised next-state and control decision for the current cycle.
  always_comb begin
    core_pc_write      = 1'b1;
    core_fetch_write   = 1'b1;
    core_if_id_flush   = 1'b0;
    core_id_ex_bubble  = 1'b0;
    core_id_ex_write   = 1'b1;
    core_ex_mem_write  = 1'b1;
    core_ex_mem_bubble = 1'b0;
    state_next         = eff_state;
    saved_state_next   = saved_state;
    cnt_next           = cnt;
    take_branch        = 1'b0;

    if (mem_stall) begin
      core_pc_write     = 1'b0;
      core_fetch_write  = 1'b0;
      core_id_ex_write  = 1'b0;
      core_ex_mem_write = 1'b0;
      state_next        = MEM_WAIT;
      saved_state_next  = eff_state;
    end else if (ex_busy) begin
      core_pc_write      = 1'b0;
      core_fetch_write   = 1'b0;
      core_id_ex_write   = 1'b0;
      core_ex_mem_bubble = 1'b1;
    end else if (eff_state == FLUSH) begin
      core_if_id_flush = 1'b1;
      if (cnt == 2'd0) begin
        state_next = RUN;
      end else begin
        cnt_next = cnt - 2'd1;
      end
    end else if ((eff_state == LOAD_STALL) || load_use) begin
      core_pc_write     = 1'b0;
      core_fetch_write  = 1'b0;
      core_id_ex_bubble = 1'b1;
      if (eff_state == LOAD_STALL) begin
        if (cnt <= 2'd1) begin
          state_next = RUN;
          cnt_next   = 2'd0;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end else if (LOAD_USE_CYCLES > 1) begin
        state_next = LOAD_STALL;
        cnt_next   = LOAD_CNT_INIT;
      end
    end else if (br_dep) begin
      core_pc_write     = 1'b0;
      core_fetch_write  = 1'b0;
      core_id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      core_if_id_flush = 1'b1;
      take_branch      = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_next = FLUSH;
        cnt_next   = FLUSH_CNT_INIT;
      end
    end
  end

  // Reset forces a safe control word so nothing advances while rst is high.
  always_comb begin
    if (rst) begin
      PCWrite       = 1'b0;
      FetchWrite    = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      PCWrite       = core_pc_write;
      FetchWrite    = core_fetch_write;
      if_id_flush   = core_if_id_flush;
      id_ex_bubble  = core_id_ex_bubble;
      id_ex_write   = core_id_ex_write;
      ex_mem_write  = core_ex_mem_write;
      ex_mem_bubble = core_ex_mem_bubble;
    end
  end

  // State, saved state and down-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= 2'd0;
    end else begin
      state       <= state_next;
      saved_state <= saved_state_next;
      cnt         <= cnt_next;
    end
  end

  // Saturating performance counters for stall cycles and accepted branch redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!core_pc_write && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (take_branch && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed bench for the hazard controller. Three instances with different
// flush/load-use lengths share one set of inputs; each step drives the inputs,
// compares the combinational control word, then clocks and checks counters.

module tb_pipeline_hazard_controller;

  // Control word order: {PCWrite, FetchWrite, if_id_flush, id_ex_bubble, id_ex_write, ex_mem_write, ex_mem_bubble}
  localparam logic [6:0] C_RST   = 7'b0011111;
  localparam logic [6:0] C_NORM  = 7'b1100110;
  localparam logic [6:0] C_STALL = 7'b0001110;
  localparam logic [6:0] C_FLUSH = 7'b1110110;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_BUSY  = 7'b0000011;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       if_id_uses_rs1, if_id_uses_rs2, if_id_is_branch;
  logic       id_ex_MemRead, id_ex_RegWrite, branch_taken, ex_busy, mem_stall;

  logic pcw_a, fw_a, fl_a, bub_a, idw_a, exw_a, exb_a;
  logic pcw_b, fw_b, fl_b, bub_b, idw_b, exw_b, exb_b;
  logic pcw_c, fw_c, fl_c, bub_c, idw_c, exw_c, exb_c;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;
  logic [1:0]  sc_c, fc_c;
  logic [6:0]  ctl_a, ctl_b, ctl_c;

  int n_compared;
  int n_mismatched;

  assign ctl_a = {pcw_a, fw_a, fl_a, bub_a, idw_a, exw_a, exb_a};
  assign ctl_b = {pcw_b, fw_b, fl_b, bub_b, idw_b, exw_b, exb_b};
  assign ctl_c = {pcw_c, fw_c, fl_c, bub_c, idw_c, exw_c, exb_c};

  pipeline_hazard_controller #(.FLUSH_CYCLES(1), .LOAD_USE_CYCLES(1), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_is_branch(if_id_is_branch), .id_ex_MemRead(id_ex_MemRead),
    .id_ex_RegWrite(id_ex_RegWrite), .id_ex_rd(id_ex_rd), .branch_taken(branch_taken),
    .ex_busy(ex_busy), .mem_stall(mem_stall), .PCWrite(pcw_a), .FetchWrite(fw_a),
    .if_id_flush(fl_a), .id_ex_bubble(bub_a), .id_ex_write(idw_a), .ex_mem_write(exw_a),
    .ex_mem_bubble(exb_a), .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_hazard_controller #(.FLUSH_CYCLES(3), .LOAD_USE_CYCLES(3), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_is_branch(if_id_is_branch), .id_ex_MemRead(id_ex_MemRead),
    .id_ex_RegWrite(id_ex_RegWrite), .id_ex_rd(id_ex_rd), .branch_taken(branch_taken),
    .ex_busy(ex_busy), .mem_stall(mem_stall), .PCWrite(pcw_b), .FetchWrite(fw_b),
    .if_id_flush(fl_b), .id_ex_bubble(bub_b), .id_ex_write(idw_b), .ex_mem_write(exw_b),
    .ex_mem_bubble(exb_b), .stall_count(sc_b), .flush_count(fc_b)
  );

  pipeline_hazard_controller #(.FLUSH_CYCLES(4), .LOAD_USE_CYCLES(2), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
    .if_id_is_branch(if_id_is_branch), .id_ex_MemRead(id_ex_MemRead),
    .id_ex_RegWrite(id_ex_RegWrite), .id_ex_rd(id_ex_rd), .branch_taken(branch_taken),
    .ex_busy(ex_busy), .mem_stall(mem_stall), .PCWrite(pcw_c), .FetchWrite(fw_c),
    .if_id_flush(fl_c), .id_ex_bubble(bub_c), .id_ex_write(idw_c), .ex_mem_write(exw_c),
    .ex_mem_bubble(exb_c), .stall_count(sc_c), .flush_count(fc_c)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic is_br,
                               input logic mread, input logic rwrite, input logic [4:0] rd,
                               input logic br, input logic busy, input logic mstall);
    if_id_rs1 = rs1;  if_id_rs2 = rs2;
    if_id_uses_rs1 = u1;  if_id_uses_rs2 = u2;  if_id_is_branch = is_br;
    id_ex_MemRead = mread;  id_ex_RegWrite = rwrite;  id_ex_rd = rd;
    branch_taken = br;  ex_busy = busy;  mem_stall = mstall;
    #2;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    idle();

    // Reset values and idle behaviour
    checkOutput("rst_ctl_a", 32'(ctl_a), 32'(C_RST));
    checkOutput("rst_ctl_c", 32'(ctl_c), 32'(C_RST));
    tick();
    tick();
    checkOutput("rst_sc_a", sc_a, 32'd0);
    checkOutput("rst_fc_a", fc_a, 32'd0);
    rst = 1'b0;
    idle();
    checkOutput("idle_ctl_a", 32'(ctl_a), 32'(C_NORM));
    tick();
    $display("[TB] reset checks done");

    // Load-use: lw x5 in EX, add x6,x5,x1 in decode
    applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ctl_a", 32'(ctl_a), 32'(C_STALL));
    checkOutput("lu_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_after_ctl_a", 32'(ctl_a), 32'(C_NORM));
    checkOutput("lu_sc_a", sc_a, 32'd1);
    checkOutput("lu3_c2_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    checkOutput("lu3_c3_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    checkOutput("lu3_done_ctl_b", 32'(ctl_b), 32'(C_NORM));
    checkOutput("lu3_sc_b", sc_b, 32'd3);

    // x0 destination never creates a hazard
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("x0_ctl_a", 32'(ctl_a), 32'(C_NORM));
    tick();
    checkOutput("x0_sc_a", sc_a, 32'd1);

    // Taken branch: 1 flush cycle on a, 3 on b, 4 on c; branch ignored inside FLUSH
    doReset();
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_c1_ctl_a", 32'(ctl_a), 32'(C_FLUSH));
    checkOutput("br_c1_ctl_b", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    checkOutput("br_fc_a", fc_a, 32'd1);
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("br_c2_ctl_a", 32'(ctl_a), 32'(C_FLUSH));
    checkOutput("br_c2_ctl_b", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    checkOutput("br_c2_fc_a", fc_a, 32'd2);
    checkOutput("br_c2_fc_b", fc_b, 32'd1);
    idle();
    checkOutput("br_c3_ctl_a", 32'(ctl_a), 32'(C_NORM));
    checkOutput("br_c3_ctl_b", 32'(ctl_b), 32'(C_FLUSH));
    tick();
    idle();
    checkOutput("br_c4_ctl_b", 32'(ctl_b), 32'(C_NORM));
    checkOutput("br_c4_ctl_c", 32'(ctl_c), 32'(C_FLUSH));
    tick();
    checkOutput("br_c5_ctl_c", 32'(ctl_c), 32'(C_NORM));
    checkOutput("br_fc_c", 32'(fc_c), 32'd1);

    // Branch operand dependency: beq x2,x3 in decode, addi x3 in EX
    doReset();
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("bd_ctl_a", 32'(ctl_a), 32'(C_STALL));
    tick();
    checkOutput("bd_fc_a", fc_a, 32'd0);
    checkOutput("bd_sc_a", sc_a, 32'd1);
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("bd_next_ctl_a", 32'(ctl_a), 32'(C_FLUSH));
    tick();
    checkOutput("bd_next_fc_a", fc_a, 32'd1);

    // Freeze for 4 cycles in the middle of a 3-cycle load stall on b
    doReset();
    applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("frz_c1_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("frz_ctl_b", 32'(ctl_b), 32'(C_FRZ));
      tick();
    end
    idle();
    checkOutput("frz_resume1_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    idle();
    checkOutput("frz_resume2_ctl_b", 32'(ctl_b), 32'(C_STALL));
    tick();
    idle();
    checkOutput("frz_done_ctl_b", 32'(ctl_b), 32'(C_NORM));
    checkOutput("frz_sc_b", sc_b, 32'd7);
    tick();

    // Branch during a freeze is not counted and is taken once the freeze lifts
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("frzbr_ctl_a", 32'(ctl_a), 32'(C_FRZ));
    tick();
    checkOutput("frzbr_fc_a", fc_a, 32'd0);
    checkOutput("frzbr_sc_a", sc_a, 32'd6);
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("frzbr_lift_ctl_a", 32'(ctl_a), 32'(C_FLUSH));
    tick();
    checkOutput("frzbr_lift_fc_a", fc_a, 32'd1);

    // EX busy for 2 cycles; a taken branch under busy is not counted
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("busy_c1_ctl_a", 32'(ctl_a), 32'(C_BUSY));
    tick();
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("busy_c2_ctl_a", 32'(ctl_a), 32'(C_BUSY));
    tick();
    checkOutput("busy_sc_a", sc_a, 32'd2);
    checkOutput("busy_fc_a", fc_a, 32'd0);
    idle();
    checkOutput("busy_done_ctl_a", 32'(ctl_a), 32'(C_NORM));
    tick();

    // Reset on the second cycle of a 4-cycle flush on c
    doReset();
    applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("rf_c1_ctl_c", 32'(ctl_c), 32'(C_FLUSH));
    tick();
    checkOutput("rf_fc_c", 32'(fc_c), 32'd1);
    rst = 1'b1;
    idle();
    checkOutput("rf_rst_ctl_c", 32'(ctl_c), 32'(C_RST));
    tick();
    rst = 1'b0;
    idle();
    checkOutput("rf_after_ctl_c", 32'(ctl_c), 32'(C_NORM));
    checkOutput("rf_after_fc_c", 32'(fc_c), 32'd0);
    checkOutput("rf_after_sc_c", 32'(sc_c), 32'd0);

    // Saturation of the 2-bit stall counter on c
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checkOutput("sat_sc_c", 32'(sc_c), 32'd3);
    checkOutput("sat_fc_c", 32'(fc_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
